capture_dump_ctrl: RTL and testbench

// - Sequences the ADC sample path: on a UART command, captures a burst of SIPO samples into block RAM.
// - Then streams the burst back through uart_tx as byte pairs.
// - Sits between sipo0/ram_test and uart_rx/uart_tx. Replaces the loopback wiring and the fixed-address RAM write.

---
 rtl/acoustics_pkg.sv | 21 ++
 rtl/capture_dump_ctrl.sv | 161 ++++++++++++++++
 tb/tb_capture_dump_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acoustics_pkg.sv
// Shared definitions for the ADC capture/dump path: controller state encoding
// and the UART command bytes that drive it.
package acoustics_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_SEND_HI = 3'd4,
        ST_SEND_LO = 3'd5,
        ST_TX_WAIT = 3'd6
    } state_t;

    localparam logic [7:0] CMD_CAPTURE_BYTE = 8'h43;  // 'C'
    localparam logic [7:0] CMD_DUMP_BYTE    = 8'h44;  // 'D'
    localparam logic [7:0] CMD_ABORT_BYTE   = 8'h58;  // 'X'

    localparam int DUMP_BYTES_PER_SAMPLE = 2;

endpackage

// File: rtl/capture_dump_ctrl.sv
// Capture a burst of SIPO samples into block RAM on a UART command, then
// stream the burst back through uart_tx as MSB/LSB byte pairs.
module capture_dump_ctrl
    import acoustics_pkg::*;
#(
    parameter int         ADDR_W      = 10,
    parameter int         DATA_W      = 10,
    parameter logic [7:0] CMD_CAPTURE = CMD_CAPTURE_BYTE,
    parameter logic [7:0] CMD_DUMP    = CMD_DUMP_BYTE,
    parameter logic [7:0] CMD_ABORT   = CMD_ABORT_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_send,
    input  logic              tx_ready,
    output logic              busy,
    output logic [2:0]        state_dbg,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t              state, state_next;
    state_t              ret, ret_next;
    logic [ADDR_W-1:0]   addr, addr_next;
    logic [DATA_W-1:0]   held;
    logic                abort;
    logic                wr_fire, send_fire, send_hi, latch, ovr_set, ovr_clr;

    assign abort     = rx_ready && (rx_data == CMD_ABORT);
    assign state_dbg = state;

    // Handshake: tx_send is a one-cycle strobe issued only after tx_ready=1 was
    // seen; the strobe cycle itself is the acceptance cycle, so tx_ready is
    // ignored while tx_send is high and the next byte waits for tx_ready=1 again.
    always_comb begin
        state_next = state;
        ret_next   = ret;
        addr_next  = addr;
        wr_fire    = 1'b0;
        send_fire  = 1'b0;
        send_hi    = 1'b0;
        latch      = 1'b0;
        ovr_set    = 1'b0;
        ovr_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_ready && rx_data == CMD_CAPTURE) begin
                    state_next = ST_CAPTURE;
                    addr_next  = '0;
                    ovr_clr    = 1'b1;
                end else if (rx_ready && rx_data == CMD_DUMP) begin
                    state_next = ST_RD_REQ;
                    addr_next  = '0;
                end
            end
            ST_CAPTURE: begin
                if (sample_valid && ram_we) begin
                    ovr_set = 1'b1;
                end
                // addr has already wrapped to 0 during the final write cycle
                if (ram_we && addr == '0) begin
                    state_next = ST_RD_REQ;
                end else if (sample_valid && !ram_we) begin
                    wr_fire   = 1'b1;
                    addr_next = addr + ADDR_W'(1);
                end
            end
            ST_RD_REQ:  state_next = ST_RD_WAIT;
            ST_RD_WAIT: begin
                latch      = 1'b1;
                state_next = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                if (tx_ready) begin
                    send_fire  = 1'b1;
                    send_hi    = 1'b1;
                    ret_next   = ST_SEND_LO;
                    state_next = ST_TX_WAIT;
                end
            end
            ST_SEND_LO: begin
                if (tx_ready) begin
                    send_fire  = 1'b1;
                    ret_next   = (addr == LAST_ADDR) ? ST_IDLE : ST_RD_REQ;
                    state_next = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                if (!tx_send && tx_ready) begin
                    state_next = ret;
                    if (ret == ST_RD_REQ) begin
                        addr_next = addr + ADDR_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
            ret_next   = ret;
            addr_next  = addr;
            wr_fire    = 1'b0;
            send_fire  = 1'b0;
            latch      = 1'b0;
            ovr_set    = 1'b0;
            ovr_clr    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ret       <= ST_IDLE;
            addr      <= '0;
            held      <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            tx_send   <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state   <= state_next;
            ret     <= ret_next;
            addr    <= addr_next;
            busy    <= (state_next != ST_IDLE);
            ram_we  <= wr_fire;
            tx_send <= send_fire;
            if (wr_fire) begin
                ram_addr  <= addr;
                ram_wdata <= sample_in;
            end else if (state_next == ST_RD_REQ) begin
                // read address is on the bus for the whole RD_REQ cycle
                ram_addr <= addr_next;
            end
            if (latch) begin
                held <= ram_rdata;
            end
            if (send_fire) begin
                tx_data <= send_hi ? 8'(held >> 8) : held[7:0];
            end
            if (ovr_clr) begin
                overrun <= 1'b0;
            end else if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_capture_dump_ctrl.sv
// Directed bench for capture_dump_ctrl with a behavioural block RAM and a
// uart_tx responder that holds tx_ready low for 20 clocks after each send.
module tb_capture_dump_ctrl;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 10;

  logic              clk;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [7:0]        tx_data;
  logic              tx_send;
  logic              tx_ready;
  logic              busy;
  logic [2:0]        state_dbg;
  logic              overrun;

  int checks = 0;
  int errors = 0;
  int tx_count = 0;
  logic prev_send = 1'b0;
  int tx_hold = 0;

  logic [7:0]               exp_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
  logic [DATA_W-1:0]        mem [0:(1<<ADDR_W)-1];

  capture_dump_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .sample_in(sample_in), .sample_valid(sample_valid), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready), .busy(busy),
    .state_dbg(state_dbg), .overrun(overrun)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // block RAM and uart_tx responders
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial tx_ready = 1'b1;
  always @(posedge clk) begin
    if (tx_send) begin
      tx_ready <= 1'b0;
      tx_hold  <= 20;
    end else if (tx_hold > 0) begin
      tx_hold <= tx_hold - 1;
      if (tx_hold == 1) tx_ready <= 1'b1;
    end
  end

  // scoreboard: transmitted bytes and RAM writes against expected queues
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_send) begin
        logic [7:0] exp_b;
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        tx_count++;
        checks++;
        assert (tx_data === exp_b) else begin
          errors++;
          $error("FAIL tx_byte%0d observed=%02h expected=%02h", tx_count, tx_data, exp_b);
        end
        checks++;
        assert (tx_ready === 1'b1) else begin
          errors++;
          $error("FAIL send_while_not_ready observed=%b expected=1", tx_ready);
        end
        checks++;
        assert (prev_send === 1'b0) else begin
          errors++;
          $error("FAIL send_back_to_back observed=%b expected=0", prev_send);
        end
      end
      if (ram_we) begin
        logic [ADDR_W+DATA_W-1:0] exp_w;
        exp_w = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : 'x;
        checks++;
        assert ({ram_addr, ram_wdata} === exp_w) else begin
          errors++;
          $error("FAIL ram_write observed=%0h/%03h expected=%0h/%03h",
                 ram_addr, ram_wdata, exp_w[ADDR_W+DATA_W-1:DATA_W], exp_w[DATA_W-1:0]);
        end
      end
    end
    prev_send = tx_send;
  end

  // driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_sample(input logic [DATA_W-1:0] v);
    @(negedge clk);
    sample_in    = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic push_pair(input logic [7:0] hi, input logic [7:0] lo);
    exp_q.push_back(hi);
    exp_q.push_back(lo);
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < budget);
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_tx(input string tag, input int target, input int budget);
    int n = 0;
    while (tx_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, tx_count, target);
  endtask

  initial begin
    int base;
    reset = 1'b1;
    rx_data = 8'h43;
    rx_ready = 1'b0;
    sample_in = 10'h155;
    sample_valid = 1'b0;

    // reset held 3 clocks while inputs toggle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {12'b0, ram_we, ram_addr, ram_wdata, tx_data, tx_send, busy, state_dbg, overrun},
            32'd0);
      rx_ready = ~rx_ready;
      sample_valid = ~sample_valid;
    end
    @(negedge clk);
    reset = 1'b0;
    rx_ready = 1'b0;
    sample_valid = 1'b0;
    check("idle_after_reset", {29'b0, state_dbg}, 32'd0);

    // capture 8 samples then automatic dump of 16 bytes
    push_wr(3'd0, 10'h3FF);
    push_pair(8'h03, 8'hFF);
    for (int k = 1; k < 8; k++) begin
      push_wr(3'(k), 10'(k));
      push_pair(8'h00, 8'(k));
    end
    send_cmd(8'h43);
    check("capture_state", {29'b0, state_dbg}, 32'd1);
    check("capture_busy", {31'b0, busy}, 32'd1);
    send_sample(10'h3FF);
    for (int k = 1; k < 8; k++) send_sample(10'(k));
    wait_idle("capture_dump_done", 2000);
    check("capture_bytes_left", exp_q.size(), 32'd0);
    check("capture_writes_left", exp_wr_q.size(), 32'd0);
    check("capture_tx_count", tx_count, 32'd16);

    // dump only: same 16 bytes, no RAM writes
    push_pair(8'h03, 8'hFF);
    for (int k = 1; k < 8; k++) push_pair(8'h00, 8'(k));
    send_cmd(8'h44);
    check("dump_state", {29'b0, state_dbg}, 32'd2);
    wait_idle("dump_done", 2000);
    check("dump_bytes_left", exp_q.size(), 32'd0);
    check("dump_tx_count", tx_count, 32'd32);

    // overrun: back-to-back strobes, second one dropped
    send_cmd(8'h43);
    push_wr(3'd0, 10'h155);
    push_wr(3'd1, 10'h2AA);
    send_sample(10'h155);
    @(negedge clk);
    sample_in = 10'h2AA;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_in = 10'h0F0;
    @(negedge clk);
    sample_valid = 1'b0;
    check("overrun_set", {31'b0, overrun}, 32'd1);
    push_pair(8'h01, 8'h55);
    push_pair(8'h02, 8'hAA);
    for (int k = 2; k < 8; k++) begin
      push_wr(3'(k), 10'h100 + 10'(k - 2));
      push_pair(8'h01, 8'(k - 2));
      send_sample(10'h100 + 10'(k - 2));
    end
    wait_idle("overrun_dump_done", 2000);
    check("overrun_sticky", {31'b0, overrun}, 32'd1);
    check("overrun_bytes_left", exp_q.size(), 32'd0);

    // next capture clears overrun; abort with simultaneous sample writes nothing
    send_cmd(8'h43);
    check("overrun_cleared", {31'b0, overrun}, 32'd0);
    push_wr(3'd0, 10'h011);
    push_wr(3'd1, 10'h022);
    send_sample(10'h011);
    send_sample(10'h022);
    @(negedge clk);
    rx_data = 8'h58;
    rx_ready = 1'b1;
    sample_in = 10'h3CC;
    sample_valid = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    sample_valid = 1'b0;
    check("abort_capture_state", {29'b0, state_dbg}, 32'd0);
    check("abort_capture_we", {31'b0, ram_we}, 32'd0);
    repeat (5) @(negedge clk);
    check("abort_capture_writes_left", exp_wr_q.size(), 32'd0);

    // abort mid-dump after 5 bytes: RAM = 011 022 100..105
    base = tx_count;
    push_pair(8'h00, 8'h11);
    push_pair(8'h00, 8'h22);
    exp_q.push_back(8'h01);
    send_cmd(8'h44);
    wait_tx("abort_dump_5_bytes", base + 5, 1000);
    send_cmd(8'h58);
    check("abort_dump_state", {29'b0, state_dbg}, 32'd0);
    check("abort_dump_busy", {31'b0, busy}, 32'd0);
    repeat (80) @(negedge clk);
    check("abort_dump_no_more_tx", tx_count, base + 5);

    // 'C' during a dump is ignored; the full 16 bytes still go out
    base = tx_count;
    push_pair(8'h00, 8'h11);
    push_pair(8'h00, 8'h22);
    for (int k = 0; k < 6; k++) push_pair(8'h01, 8'(k));
    send_cmd(8'h44);
    wait_tx("dump_c_3_bytes", base + 3, 1000);
    send_cmd(8'h43);
    check("dump_c_not_capture", {31'b0, state_dbg == 3'd1}, 32'd0);
    send_sample(10'h3AB);
    wait_idle("dump_c_done", 2000);
    check("dump_c_tx_count", tx_count, base + 16);
    check("dump_c_bytes_left", exp_q.size(), 32'd0);

    // reset in the middle of a capture returns to idle
    send_cmd(8'h43);
    push_wr(3'd0, 10'h0AB);
    send_sample(10'h0AB);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midop_reset", {27'b0, busy, state_dbg, overrun}, 32'd0);
    reset = 1'b0;
    check("midop_writes_left", exp_wr_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $error("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
